// File: rtl/am2940_pkg.sv
// Shared definitions for the am2940 DMA control stage: instruction codes,
// sequencer state encoding and default slice width.
package am2940_pkg;

   localparam int DATA_W_DEF = 4;

   localparam logic [2:0] I_WRCR   = 3'd0;
   localparam logic [2:0] I_RDCR   = 3'd1;
   localparam logic [2:0] I_RDWC   = 3'd2;
   localparam logic [2:0] I_RDAC   = 3'd3;
   localparam logic [2:0] I_REINIT = 3'd4;
   localparam logic [2:0] I_LDAD   = 3'd5;
   localparam logic [2:0] I_LDWC   = 3'd6;
   localparam logic [2:0] I_ENCNT  = 3'd7;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LD_CR,
      S_LD_AD,
      S_LD_WC,
      S_ARM,
      S_WAIT_REQ,
      S_XFER,
      S_STEP,
      S_FIN
   } state_t;

endpackage

// File: rtl/am2940_dma_sequencer_if.sv
// Bus between the DMA sequencer, the am2940 slice and the peripheral handshake.
interface am2940_dma_sequencer_if #(
   parameter int DATA_W = 4
);
   logic              trans;
   logic [2:0]        instr;
   logic [DATA_W-1:0] d_out;
   logic              noea;
   logic              aci;
   logic              wci;
   logic              dack;
   logic              done;
   logic              drq;

   modport master (
      output trans, instr, d_out, noea, aci, wci, dack,
      input  done, drq
   );

   modport slave (
      input  trans, instr, d_out, noea, aci, wci, dack,
      output done, drq
   );
endinterface

// File: rtl/am2940_cmd_issue.sv
// Two-cycle am2940 command generator: SETUP (code/data driven, trans low)
// followed by STROBE (trans high, code/data held); ack is the STROBE cycle.
module am2940_cmd_issue
   import am2940_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              res,
   input  logic              req,
   input  logic [2:0]        code,
   input  logic [DATA_W-1:0] data,
   input  logic [2:0]        park_code,
   output logic              trans,
   output logic [2:0]        instr,
   output logic [DATA_W-1:0] d_out,
   output logic              ack,
   output logic              busy
);

   logic              act_q,   act_d;
   logic              trans_q, trans_d;
   logic [2:0]        instr_q, instr_d;
   logic [DATA_W-1:0] d_q,     d_d;

   always_comb begin
      act_d   = act_q;
      trans_d = trans_q;
      instr_d = instr_q;
      d_d     = d_q;
      if (req) begin
         act_d   = 1'b1;
         trans_d = 1'b0;
         instr_d = code;
         d_d     = data;
      end else if (act_q && !trans_q) begin
         trans_d = 1'b1;
      end else begin
         // between commands the bus parks on a non-modifying code
         act_d   = 1'b0;
         trans_d = 1'b0;
         instr_d = park_code;
         d_d     = '0;
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         act_q   <= 1'b0;
         trans_q <= 1'b0;
         instr_q <= I_RDCR;
         d_q     <= '0;
      end else begin
         act_q   <= act_d;
         trans_q <= trans_d;
         instr_q <= instr_d;
         d_q     <= d_d;
      end
   end

   assign trans = trans_q;
   assign instr = instr_q;
   assign d_out = d_q;
   assign ack   = trans_q;
   assign busy  = act_q;

endmodule

// File: rtl/am2940_dma_sequencer.sv
// DMA control stage in front of am2940_top: programs CR/address/count, then
// runs DRQ/DACK transfers until DONE. Optional: AM2940_DMA_AUTO_REINIT_EN.
//
// state    | meaning
// IDLE     | waiting for a start rising edge
// LD_CR    | WRITE CR command with cfg_ctrl
// LD_AD    | LOAD ADDR command with captured address
// LD_WC    | LOAD WC command with captured count
// ARM      | one cycle to sample done before any transfer
// WAIT_REQ | parked on ENABLE COUNT, waiting for drq
// XFER     | dack high, address bus driven, XFER_CYCLES clk
// STEP     | ENABLE COUNT command with aci/wci, counts one transfer
// FIN      | irq pulse; optionally REINIT then resume
module am2940_dma_sequencer
   import am2940_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int XFER_CYCLES = 2,
   parameter int CNT_W       = 8
) (
   input  logic                   clk,
   input  logic                   res,
   input  logic                   start,
   input  logic                   abort,
   input  logic [2:0]             cfg_ctrl,
   input  logic [DATA_W-1:0]      cfg_addr,
   input  logic [DATA_W-1:0]      cfg_count,
   output logic                   busy,
   output logic                   irq,
   output logic [CNT_W-1:0]       xfer_cnt,
   am2940_dma_sequencer_if.master bus
);

   localparam logic [3:0] XFER_LOAD = 4'(XFER_CYCLES - 1);

   state_t            state_q,      state_d;
   logic [DATA_W-1:0] addr_q,       addr_d;
   logic [DATA_W-1:0] count_q,      count_d;
   logic [3:0]        timer_q,      timer_d;
   logic [CNT_W-1:0]  xfer_cnt_q,   xfer_cnt_d;
   logic              abort_pend_q, abort_pend_d;
   logic              start_prev_q, start_prev_d;
   logic              noea_q,       noea_d;
   logic              dack_q,       dack_d;
   logic              acwc_q,       acwc_d;
   logic              busy_q,       busy_d;
   logic              irq_q,        irq_d;

   logic              cmd_req;
   logic [2:0]        cmd_code;
   logic [DATA_W-1:0] cmd_data;
   logic [2:0]        park_code;
   logic              cmd_trans, cmd_ack, cmd_busy;
   logic [2:0]        cmd_instr;
   logic [DATA_W-1:0] cmd_dout;
   logic              abort_any;
   logic              reinit_ok;

   assign abort_any = abort | abort_pend_q;

`ifdef AM2940_DMA_AUTO_REINIT_EN
   assign reinit_ok = bus.done && !abort_any;
`else
   assign reinit_ok = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      count_d      = count_q;
      timer_d      = timer_q;
      xfer_cnt_d   = xfer_cnt_q;
      abort_pend_d = abort_pend_q | abort;
      start_prev_d = start;
      cmd_req      = 1'b0;
      cmd_code     = I_RDCR;
      cmd_data     = '0;

      case (state_q)
         S_IDLE: begin
            abort_pend_d = 1'b0;
            if (start && !start_prev_q) begin
               state_d    = S_LD_CR;
               addr_d     = cfg_addr;
               count_d    = cfg_count;
               xfer_cnt_d = '0;
               cmd_req    = 1'b1;
               cmd_code   = I_WRCR;
               cmd_data   = DATA_W'(cfg_ctrl);
            end
         end
         S_LD_CR: begin
            if (cmd_ack) begin
               if (abort_any) begin
                  state_d = S_FIN;
               end else begin
                  state_d  = S_LD_AD;
                  cmd_req  = 1'b1;
                  cmd_code = I_LDAD;
                  cmd_data = addr_q;
               end
            end
         end
         S_LD_AD: begin
            if (cmd_ack) begin
               if (abort_any) begin
                  state_d = S_FIN;
               end else begin
                  state_d  = S_LD_WC;
                  cmd_req  = 1'b1;
                  cmd_code = I_LDWC;
                  cmd_data = count_q;
               end
            end
         end
         S_LD_WC: begin
            if (cmd_ack) state_d = abort_any ? S_FIN : S_ARM;
         end
         S_ARM: begin
            if (bus.done || abort_any) begin
               state_d  = S_FIN;
               cmd_req  = reinit_ok;
               cmd_code = I_REINIT;
            end else begin
               state_d = S_WAIT_REQ;
            end
         end
         S_WAIT_REQ: begin
            if (abort_any) begin
               state_d = S_FIN;
            end else if (bus.drq) begin
               state_d = S_XFER;
               timer_d = XFER_LOAD;
            end
         end
         S_XFER: begin
            if (timer_q == 4'd0) begin
               state_d  = S_STEP;
               cmd_req  = 1'b1;
               cmd_code = I_ENCNT;
            end else begin
               timer_d = timer_q - 4'd1;
            end
         end
         S_STEP: begin
            if (cmd_ack) begin
               if (xfer_cnt_q != '1) xfer_cnt_d = xfer_cnt_q + 1'b1;
               if (bus.done || abort_any) begin
                  state_d  = S_FIN;
                  cmd_req  = reinit_ok;
                  cmd_code = I_REINIT;
               end else begin
                  state_d = S_WAIT_REQ;
               end
            end
         end
         S_FIN: begin
            // only a REINIT keeps the command generator busy here
            if (!cmd_busy)    state_d = S_IDLE;
            else if (cmd_ack) state_d = start ? S_WAIT_REQ : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      park_code = (state_d == S_WAIT_REQ || state_d == S_XFER || state_d == S_STEP)
                  ? I_ENCNT : I_RDCR;

      busy_d = (state_d != S_IDLE);
      dack_d = (state_d == S_XFER);
      noea_d = !dack_d;
      acwc_d = (state_d == S_STEP);
      irq_d  = (state_d == S_FIN) && (state_q != S_FIN);
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         count_q      <= '0;
         timer_q      <= '0;
         xfer_cnt_q   <= '0;
         abort_pend_q <= 1'b0;
         // a start level already high at reset release must not launch a run
         start_prev_q <= 1'b1;
         noea_q       <= 1'b1;
         dack_q       <= 1'b0;
         acwc_q       <= 1'b0;
         busy_q       <= 1'b0;
         irq_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         count_q      <= count_d;
         timer_q      <= timer_d;
         xfer_cnt_q   <= xfer_cnt_d;
         abort_pend_q <= abort_pend_d;
         start_prev_q <= start_prev_d;
         noea_q       <= noea_d;
         dack_q       <= dack_d;
         acwc_q       <= acwc_d;
         busy_q       <= busy_d;
         irq_q        <= irq_d;
      end
   end

   am2940_cmd_issue #(.DATA_W(DATA_W)) u_cmd (
      .clk       (clk),
      .res       (res),
      .req       (cmd_req),
      .code      (cmd_code),
      .data      (cmd_data),
      .park_code (park_code),
      .trans     (cmd_trans),
      .instr     (cmd_instr),
      .d_out     (cmd_dout),
      .ack       (cmd_ack),
      .busy      (cmd_busy)
   );

   assign bus.trans = cmd_trans;
   assign bus.instr = cmd_instr;
   assign bus.d_out = cmd_dout;
   assign bus.noea  = noea_q;
   assign bus.dack  = dack_q;
   assign bus.aci   = acwc_q;
   assign bus.wci   = acwc_q;
   assign busy      = busy_q;
   assign irq       = irq_q;
   assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_am2940_dma_sequencer.sv
// Directed bench for am2940_dma_sequencer with a small am2940 word-count/DONE model.
module tb_am2940_dma_sequencer;
   import am2940_pkg::*;

   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          res;
   logic          start, abort, drq;
   logic [2:0]    cfg_ctrl;
   logic [DW-1:0] cfg_addr, cfg_count;
   logic          busy, irq;
   logic [7:0]    xfer_cnt;

   int n_cmp = 0;
   int n_mis = 0;

   int irqs, reinits;
   bit dropped, ended;

   am2940_dma_sequencer_if #(.DATA_W(DW)) bus ();

   am2940_dma_sequencer #(.DATA_W(DW), .XFER_CYCLES(2), .CNT_W(8)) dut (
      .clk       (clk),
      .res       (res),
      .start     (start),
      .abort     (abort),
      .cfg_ctrl  (cfg_ctrl),
      .cfg_addr  (cfg_addr),
      .cfg_count (cfg_count),
      .busy      (busy),
      .irq       (irq),
      .xfer_cnt  (xfer_cnt),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   // am2940 model: LOAD WC sets the count, counted ENABLE COUNT strobes advance it
   logic [DW-1:0] wc_reg   = '0;
   int            step_cnt = 0;
   always @(negedge clk) begin
      if (bus.trans) begin
         if (bus.instr == I_LDWC) begin
            wc_reg   <= bus.d_out;
            step_cnt <= 0;
         end else if (bus.instr == I_REINIT) begin
            step_cnt <= 0;
         end else if (bus.instr == I_ENCNT && bus.wci) begin
            step_cnt <= step_cnt + 1;
         end
      end
   end
   assign bus.done = (step_cnt >= int'(wc_reg));
   assign bus.drq  = drq;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   initial begin
      res = 1'b1; start = 1'b0; abort = 1'b0; drq = 1'b0;
      cfg_ctrl = '0; cfg_addr = '0; cfg_count = '0;
      cyc(2);
      res = 1'b0;
      cyc(1);
      chk("rst_trans", bus.trans, 0);
      chk("rst_instr", bus.instr, 1);
      chk("rst_dout",  bus.d_out, 0);
      chk("rst_noea",  bus.noea,  1);
      chk("rst_aci",   bus.aci,   0);
      chk("rst_wci",   bus.wci,   0);
      chk("rst_dack",  bus.dack,  0);
      chk("rst_busy",  busy,      0);
      chk("rst_irq",   irq,       0);
      chk("rst_cnt",   xfer_cnt,  0);

      // programming and four transfers
      cfg_ctrl = 3'b010; cfg_addr = 4'h3; cfg_count = 4'h4; drq = 1'b1; start = 1'b1;
      cyc(1);
      chk("cr_setup_instr", bus.instr, 0);
      chk("cr_setup_dout",  bus.d_out, 2);
      chk("cr_setup_trans", bus.trans, 0);
      chk("cr_busy",        busy,      1);
      cfg_addr = 4'hF; start = 1'b0;
      cyc(1);
      chk("cr_strobe_trans", bus.trans, 1);
      chk("cr_strobe_instr", bus.instr, 0);
      chk("cr_strobe_dout",  bus.d_out, 2);
      cyc(1);
      chk("ad_setup_instr", bus.instr, 5);
      chk("ad_setup_dout",  bus.d_out, 3);
      chk("ad_setup_trans", bus.trans, 0);
      cyc(1);
      chk("ad_strobe_trans", bus.trans, 1);
      chk("ad_strobe_dout",  bus.d_out, 3);
      cyc(1);
      chk("wc_setup_instr", bus.instr, 6);
      chk("wc_setup_dout",  bus.d_out, 4);
      cyc(1);
      chk("wc_strobe_trans", bus.trans, 1);
      chk("wc_strobe_instr", bus.instr, 6);
      cyc(1);
      chk("arm_instr", bus.instr, 1);
      chk("arm_dack",  bus.dack,  0);
      chk("arm_busy",  busy,      1);
      for (int k = 0; k < 4; k++) begin
         cyc(1);
         chk("wait_instr", bus.instr, 7);
         chk("wait_noea",  bus.noea,  1);
         chk("wait_dack",  bus.dack,  0);
         chk("wait_cnt",   xfer_cnt,  k);
         for (int j = 0; j < 2; j++) begin
            cyc(1);
            chk("xfer_dack", bus.dack, 1);
            chk("xfer_noea", bus.noea, 0);
            chk("xfer_aci",  bus.aci,  0);
            chk("xfer_wci",  bus.wci,  0);
         end
         cyc(1);
         chk("step_setup_aci",   bus.aci,   1);
         chk("step_setup_wci",   bus.wci,   1);
         chk("step_setup_trans", bus.trans, 0);
         chk("step_setup_dack",  bus.dack,  0);
         cyc(1);
         chk("step_strobe_trans", bus.trans, 1);
         chk("step_strobe_aci",   bus.aci,   1);
         chk("step_strobe_instr", bus.instr, 7);
      end
      cyc(1);
      chk("fin_irq", irq,      1);
      chk("fin_cnt", xfer_cnt, 4);
      chk("fin_aci", bus.aci,  0);
`ifdef AM2940_DMA_AUTO_REINIT_EN
      cyc(1);
`endif
      cyc(1);
      chk("idle_busy",  busy,      0);
      chk("idle_irq",   irq,       0);
      chk("idle_instr", bus.instr, 1);
      chk("idle_cnt",   xfer_cnt,  4);

      // zero count: done already high at ARM, start held afterwards
      cfg_ctrl = 3'b001; cfg_addr = 4'h7; cfg_count = 4'h0; start = 1'b1;
      cyc(7);
      chk("zc_arm_busy", busy,     1);
      chk("zc_arm_irq",  irq,      0);
      chk("zc_arm_dack", bus.dack, 0);
`ifdef AM2940_DMA_AUTO_REINIT_EN
      start = 1'b0;
`endif
      cyc(1);
      chk("zc_irq",  irq,      1);
      chk("zc_dack", bus.dack, 0);
      chk("zc_cnt",  xfer_cnt, 0);
`ifdef AM2940_DMA_AUTO_REINIT_EN
      cyc(1);
`endif
      cyc(1);
      chk("zc_idle", busy, 0);
      chk("zc_irq_off", irq, 0);
      cyc(2);
      chk("zc_no_restart", busy, 0);
      start = 1'b0;
      cyc(1);

      // abort in the first dack cycle
      cfg_count = 4'h4; drq = 1'b1; start = 1'b1;
      cyc(9);
      chk("ab_dack1", bus.dack, 1);
      abort = 1'b1;
      cyc(1);
      chk("ab_dack2", bus.dack, 1);
      chk("ab_noea2", bus.noea, 0);
      abort = 1'b0;
      cyc(1);
      chk("ab_step_aci",   bus.aci,   1);
      chk("ab_step_trans", bus.trans, 0);
      chk("ab_step_dack",  bus.dack,  0);
      cyc(1);
      chk("ab_step_strobe", bus.trans, 1);
      cyc(1);
      chk("ab_irq", irq,      1);
      chk("ab_cnt", xfer_cnt, 1);
      cyc(1);
      chk("ab_idle", busy, 0);
      start = 1'b0;
      cyc(1);

      // reset in the middle of a strobe, start held through release
      start = 1'b1;
      cyc(2);
      chk("rs_pre_trans", bus.trans, 1);
      res = 1'b1;
      #1;
      chk("rs_trans", bus.trans, 0);
      chk("rs_noea",  bus.noea,  1);
      chk("rs_dack",  bus.dack,  0);
      chk("rs_busy",  busy,      0);
      chk("rs_instr", bus.instr, 1);
      cyc(1);
      res = 1'b0;
      cyc(3);
      chk("rs_no_restart", busy,      0);
      chk("rs_no_trans",   bus.trans, 0);
      start = 1'b0;
      cyc(1);

      // fresh start after reset, abort while waiting for drq
      drq = 1'b0; start = 1'b1;
      cyc(1);
      chk("rs2_busy", busy, 1);
      start = 1'b0;
      cyc(7);
      chk("wq_instr", bus.instr, 7);
      chk("wq_dack",  bus.dack,  0);
      abort = 1'b1;
      cyc(1);
      abort = 1'b0;
      chk("wq_irq",  irq,      1);
      chk("wq_cnt",  xfer_cnt, 0);
      cyc(1);
      chk("wq_idle", busy, 0);

`ifdef AM2940_DMA_AUTO_REINIT_EN
      cyc(1);
      irqs = 0; reinits = 0; dropped = 1'b0; ended = 1'b0;
      cfg_count = 4'h2; drq = 1'b1; start = 1'b1;
      for (int i = 0; i < 200 && !ended; i++) begin
         cyc(1);
         if (irq) irqs++;
         if (bus.trans && bus.instr == I_REINIT) reinits++;
         if (irqs == 2 && !dropped) begin
            start   = 1'b0;
            dropped = 1'b1;
         end else if (dropped && !busy) begin
            ended = 1'b1;
         end
      end
      chk("ar_ended",   ended,    1);
      chk("ar_irqs",    irqs,     2);
      chk("ar_reinits", reinits,  2);
      chk("ar_cnt",     xfer_cnt, 4);
      drq = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
